// File: rtl/spi_register_file.sv
// Register bank fed by an SPI slave word stream: one command word per frame, then
// auto-incrementing writes or reads. All registers are exported on a flat bus.
module spi_register_file #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned ADDR_BITS = 4
) (
   input  logic                            system_clk,
   input  logic                            system_rst_n,
   input  logic                            cs_start,
   input  logic                            cs_stop,
   input  logic                            value_valid,
   input  logic [WIDTH-1:0]                value_mosi,
   output logic [WIDTH-1:0]                value_miso,
   output logic [WIDTH*(2**ADDR_BITS)-1:0] regs_flat,
   output logic                            reg_write,
   output logic [ADDR_BITS-1:0]            reg_write_addr
);

   localparam int unsigned NUM_REGS = 2**ADDR_BITS;

   typedef enum logic [1:0] {StIdle, StCmd, StWrite, StRead} state_e;

   state_e               state_q;
   logic [ADDR_BITS-1:0] addr_q;
   logic [WIDTH-1:0]     value_miso_q;
   logic                 reg_write_q;
   logic [ADDR_BITS-1:0] reg_write_addr_q;
   logic [WIDTH-1:0]     regs_q [NUM_REGS];

   logic [ADDR_BITS-1:0] cmd_addr;
   assign cmd_addr = value_mosi[ADDR_BITS-1:0];

   always_ff @(posedge system_clk or negedge system_rst_n) begin
      if (!system_rst_n) begin
         state_q          <= StIdle;
         addr_q           <= '0;
         value_miso_q     <= '0;
         reg_write_q      <= 1'b0;
         reg_write_addr_q <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         reg_write_q <= 1'b0;
         if (cs_start) begin
            // A start always (re)opens a frame; any word in the same cycle is dropped.
            state_q      <= StCmd;
            value_miso_q <= '0;
         end else begin
            if (value_valid) begin
               unique case (state_q)
                  StCmd: begin
                     if (value_mosi[WIDTH-1]) begin
                        state_q <= StWrite;
                        addr_q  <= cmd_addr;
                     end else begin
                        state_q      <= StRead;
                        value_miso_q <= regs_q[cmd_addr];
                        addr_q       <= cmd_addr + 1'b1;
                     end
                  end
                  StWrite: begin
                     regs_q[addr_q]   <= value_mosi;
                     reg_write_q      <= 1'b1;
                     reg_write_addr_q <= addr_q;
                     addr_q           <= addr_q + 1'b1;
                  end
                  StRead: begin
                     value_miso_q <= regs_q[addr_q];
                     addr_q       <= addr_q + 1'b1;
                  end
                  default: ;
               endcase
            end
            // Stop overrides the state update, so a word arriving with it still lands.
            if (cs_stop) begin
               state_q <= StIdle;
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
      assign regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
   end

   assign value_miso     = value_miso_q;
   assign reg_write      = reg_write_q;
   assign reg_write_addr = reg_write_addr_q;

endmodule

// File: tb/tb_spi_register_file.sv
// Bench for spi_register_file: directed frames plus random traffic, all compared
// cycle by cycle against a frame-level reference model.
module tb_spi_register_file;

   localparam int WIDTH = 8;
   localparam int ADDR_BITS = 4;
   localparam int NREG = 16;
   localparam int FLAT = WIDTH * NREG;

   localparam int M_IDLE = 0;
   localparam int M_CMD = 1;
   localparam int M_WRITE = 2;
   localparam int M_READ = 3;

   logic                 system_clk = 1'b0;
   logic                 system_rst_n = 1'b0;
   logic                 cs_start = 1'b0;
   logic                 cs_stop = 1'b0;
   logic                 value_valid = 1'b0;
   logic [WIDTH-1:0]     value_mosi = '0;
   logic [WIDTH-1:0]     value_miso;
   logic [FLAT-1:0]      regs_flat;
   logic                 reg_write;
   logic [ADDR_BITS-1:0] reg_write_addr;

   int checks = 0;
   int errors = 0;
   int write_pulses = 0;

   // Reference model state
   logic [7:0] m_regs [NREG];
   int         m_mode;
   int         m_addr;
   logic [7:0] exp_miso;
   logic       exp_we;
   int         exp_waddr;

   spi_register_file #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
      .system_clk     (system_clk),
      .system_rst_n   (system_rst_n),
      .cs_start       (cs_start),
      .cs_stop        (cs_stop),
      .value_valid    (value_valid),
      .value_mosi     (value_mosi),
      .value_miso     (value_miso),
      .regs_flat      (regs_flat),
      .reg_write      (reg_write),
      .reg_write_addr (reg_write_addr)
   );

   always #5 system_clk = ~system_clk;

   task automatic check_value(input string tag, input logic [FLAT-1:0] got,
                              input logic [FLAT-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [FLAT-1:0] model_flat();
      logic [FLAT-1:0] f;
      for (int i = 0; i < NREG; i++) f[i*WIDTH +: WIDTH] = m_regs[i];
      return f;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
      m_mode = M_IDLE;
      m_addr = 0;
      exp_miso = 8'h00;
      exp_we = 1'b0;
      exp_waddr = 0;
   endtask

   task automatic check_outputs(input string tag);
      check_value({tag, ".regs"}, regs_flat, model_flat());
      check_value({tag, ".miso"}, FLAT'(value_miso), FLAT'(exp_miso));
      check_value({tag, ".we"}, FLAT'(reg_write), FLAT'(exp_we));
      if (exp_we) check_value({tag, ".waddr"}, FLAT'(reg_write_addr), FLAT'(exp_waddr));
   endtask

   // One clock with the given pulses; model the frame semantics and compare.
   task automatic cyc(input logic s, input logic p, input logic v, input logic [7:0] d,
                      input string tag);
      cs_start = s;
      cs_stop = p;
      value_valid = v;
      value_mosi = d;
      @(posedge system_clk);
      #1;
      cs_start = 1'b0;
      cs_stop = 1'b0;
      value_valid = 1'b0;
      value_mosi = '0;
      exp_we = 1'b0;
      if (s) begin
         m_mode = M_CMD;
         exp_miso = 8'h00;
      end else begin
         if (v && m_mode == M_CMD) begin
            m_addr = int'(d[3:0]);
            if (d[7]) m_mode = M_WRITE;
            else begin
               exp_miso = m_regs[m_addr];
               m_addr = (m_addr + 1) % NREG;
               m_mode = M_READ;
            end
         end else if (v && m_mode == M_WRITE) begin
            m_regs[m_addr] = d;
            exp_we = 1'b1;
            exp_waddr = m_addr;
            m_addr = (m_addr + 1) % NREG;
         end else if (v && m_mode == M_READ) begin
            exp_miso = m_regs[m_addr];
            m_addr = (m_addr + 1) % NREG;
         end
         if (p) m_mode = M_IDLE;
      end
      if (reg_write) write_pulses++;
      check_outputs(tag);
   endtask

   initial begin
      int wp;
      model_reset();
      repeat (3) @(posedge system_clk);
      #1;
      check_outputs("reset");
      check_value("reset.waddr", FLAT'(reg_write_addr), '0);
      system_rst_n = 1'b1;
      repeat (3) cyc(0, 0, 0, 8'h00, "idle");

      // Write frame
      wp = write_pulses;
      cyc(1, 0, 0, 8'h00, "wr.start");
      cyc(0, 0, 1, 8'h83, "wr.cmd");
      cyc(0, 0, 1, 8'h11, "wr.d0");
      check_value("wr.addr3", FLAT'(reg_write_addr), FLAT'(3));
      cyc(0, 0, 1, 8'h22, "wr.d1");
      check_value("wr.addr4", FLAT'(reg_write_addr), FLAT'(4));
      cyc(0, 1, 0, 8'h00, "wr.stop");
      check_value("wr.pulses", FLAT'(write_pulses - wp), FLAT'(2));
      check_value("wr.reg3", FLAT'(regs_flat[31:24]), FLAT'(8'h11));
      check_value("wr.reg4", FLAT'(regs_flat[39:32]), FLAT'(8'h22));

      // Read frame
      wp = write_pulses;
      cyc(1, 0, 0, 8'h00, "rd.start");
      cyc(0, 0, 1, 8'h03, "rd.cmd");
      check_value("rd.w1", FLAT'(value_miso), FLAT'(8'h11));
      cyc(0, 0, 1, 8'h00, "rd.d0");
      check_value("rd.w2", FLAT'(value_miso), FLAT'(8'h22));
      cyc(0, 0, 1, 8'h00, "rd.d1");
      check_value("rd.w3", FLAT'(value_miso), FLAT'(8'h00));
      cyc(0, 1, 0, 8'h00, "rd.stop");
      check_value("rd.pulses", FLAT'(write_pulses - wp), FLAT'(0));

      // Wrap-around
      cyc(1, 0, 0, 8'h00, "wrap.start");
      cyc(0, 0, 1, 8'h8F, "wrap.cmd");
      cyc(0, 0, 1, 8'hAA, "wrap.d0");
      check_value("wrap.addr15", FLAT'(reg_write_addr), FLAT'(15));
      cyc(0, 0, 1, 8'hBB, "wrap.d1");
      check_value("wrap.addr0", FLAT'(reg_write_addr), FLAT'(0));
      cyc(0, 1, 0, 8'h00, "wrap.stop");
      cyc(1, 0, 0, 8'h00, "wrapr.start");
      cyc(0, 0, 1, 8'h0F, "wrapr.cmd");
      check_value("wrapr.w1", FLAT'(value_miso), FLAT'(8'hAA));
      cyc(0, 0, 1, 8'h00, "wrapr.d0");
      check_value("wrapr.w2", FLAT'(value_miso), FLAT'(8'hBB));
      cyc(0, 1, 0, 8'h00, "wrapr.stop");

      // Abort and ignore
      cyc(1, 0, 0, 8'h00, "abort.start");
      cyc(0, 0, 1, 8'h85, "abort.cmd");
      cyc(0, 1, 0, 8'h00, "abort.stop");
      check_value("abort.reg5", FLAT'(regs_flat[47:40]), FLAT'(8'h00));
      cyc(0, 0, 1, 8'h55, "idle.valid");
      cyc(1, 0, 0, 8'h00, "stopw.start");
      cyc(0, 0, 1, 8'h86, "stopw.cmd");
      cyc(0, 1, 1, 8'h77, "stopw.last");
      check_value("stopw.reg6", FLAT'(regs_flat[55:48]), FLAT'(8'h77));
      cyc(0, 0, 1, 8'h66, "stopw.after");

      // Reset mid-frame
      cyc(1, 0, 0, 8'h00, "rst.start");
      cyc(0, 0, 1, 8'h82, "rst.cmd");
      cyc(0, 0, 1, 8'h99, "rst.d0");
      system_rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("rst.async");
      @(posedge system_clk);
      #1;
      system_rst_n = 1'b1;
      cyc(0, 0, 1, 8'h44, "rst.ignored");
      check_value("rst.allzero", regs_flat, '0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic s, p, v;
         s = ($urandom_range(0, 9) == 0);
         p = ($urandom_range(0, 9) == 0);
         v = !s && ($urandom_range(0, 1) == 1);
         cyc(s, p, v, 8'($urandom), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
